// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state, funct3 codes and misalignment rule for the data-memory responder
package dmem_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} dmem_state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      return ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) || (funct3 == F3_W && addr_lo != 2'b00);
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load extraction/extension and store byte-lane merge.
// DMEM_MISALIGN_CHECK_EN suppresses misaligned accesses; otherwise low address bits are masked.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [3:0]  byte_en,
   output logic [31:0] wr_word,
   output logic        misalign
);
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] ld;
   logic [31:0] rep;
   logic [3:0]  be;
   always_comb begin
      b   = word[{addr_lo, 3'b000} +: 8];
      h   = addr_lo[1] ? word[31:16] : word[15:0];
      ld  = funct3 == F3_B  ? {{24{b[7]}}, b}  :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_W  ? word             :
            funct3 == F3_BU ? {24'd0, b}       :
            funct3 == F3_HU ? {16'd0, h}       : 32'd0;
      be  = funct3 == F3_B ? 4'b0001 << addr_lo :
            funct3 == F3_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
            funct3 == F3_W ? 4'b1111 : 4'b0000;
      rep = funct3 == F3_B ? {4{wdata[7:0]}} : funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign = is_misaligned(funct3, addr_lo);
`else
      misalign = 1'b0;
`endif
      load_data = misalign ? 32'd0 : ld;
      byte_en   = misalign ? 4'b0000 : be;
      for (int i = 0; i < 4; i++)
         wr_word[8*i +: 8] = byte_en[i] ? rep[8*i +: 8] : word[8*i +: 8];
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressed data RAM for the MEM-stage port with optional wait states and busy stall.
// Misaligned-access trapping is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_funct3,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  misalign
);
   localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
   localparam logic zw = (WAIT_CYCLES == 0);
   localparam logic [3:0] N_M1 = zw ? 4'd0 : 4'(WAIT_CYCLES - 1);
   logic [DATA_W-1:0] mem [DEPTH];
   dmem_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d, a;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, wd;
   logic [2:0] f3_q, f3_d, f3;
   logic rd_q, rd_d, wr_q, wr_d, mis_q, mis_d;
   logic [DATA_W-1:0] load, wword;
   logic [3:0] be;
   logic mis, req, commit;
   // Zero-wait builds act directly on the live request; otherwise on the latched copy.
   always_comb begin
      req = req_read | req_write;
      a   = zw ? req_addr : addr_q;
      wd  = zw ? req_wdata : wdata_q;
      f3  = zw ? req_funct3 : f3_q;
   end
   dmem_lane_align u_align (
      .word      (mem[a[DM_ADDRESS-1:2]]),
      .addr_lo   (a[1:0]),
      .funct3    (f3),
      .wdata     (wd),
      .load_data (load),
      .byte_en   (be),
      .wr_word   (wword),
      .misalign  (mis)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      mis_d   = mis_q;
      commit  = zw & req_write;
      busy    = 1'b0;
      done    = zw & req;
      if (!zw) begin
         case (state_q)
            IDLE: if (req) begin
               busy    = 1'b1;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               f3_d    = req_funct3;
               rd_d    = req_read;
               wr_d    = req_write;
               cnt_d   = N_M1;
               state_d = WAIT;
            end
            WAIT: begin
               busy = 1'b1;
               if (cnt_q == 4'd0) begin
                  commit  = wr_q;
                  rdata_d = (rd_q & ~wr_q) ? load : '0;
                  mis_d   = mis;
                  state_d = DONE;
               end else
                  cnt_d = cnt_q - 4'd1;
            end
            DONE: begin
               done    = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      rsp_rdata = zw ? ((req_read & ~req_write) ? load : '0) : rdata_q;
      misalign  = zw ? (req & mis) : (state_q == DONE) & mis_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= 3'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end
   // RAM is never cleared; reset only blocks a commit in the same cycle.
   always_ff @(posedge clk)
      if (commit && !reset && |be) mem[a[DM_ADDRESS-1:2]] <= wword;
endmodule
